clint_timer: RTL

- Core-local interruptor that generates the `trint` and `swint` inputs consumed by the machine-mode CSR/trap unit.
- Holds `msip`, `mtimecmp` and the free-running `mtime`, all memory-mapped on a simple single-outstanding request/response port.
- Sits beside the memory stage on the uncached device path. Loads and stores to its address window are routed here instead of the data cache.

---
 rtl/clint_timer.sv | 118 +++++++++++
 1 files changed

// File: rtl/clint_timer.sv
// Core-local interruptor: msip, mtimecmp and free-running mtime behind a
// single-outstanding request/response port; drives trint and swint.
module clint_timer #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [7:0]  req_strobe,
  input  logic [63:0] req_data,
  output logic        resp_valid,
  output logic [63:0] resp_data,
  output logic        resp_error,
  output logic        trint,
  output logic        swint
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

  typedef enum logic {IDLE, RESP} state_t;

  state_t        state;
  logic [63:0]   mtime;
  logic [63:0]   mtimecmp;
  logic          msip;
  logic [PW-1:0] prescaler;

  logic          tick;
  logic          in_window;
  logic          sel_msip;
  logic          sel_cmp;
  logic          sel_time;
  logic          hit;
  logic          wr;
  logic [63:0]   mask;
  logic [63:0]   rdata;
  logic          unused_addr_bits;

  assign unused_addr_bits = ^req_addr[2:0];

  assign tick      = (prescaler == PS_LAST);
  assign in_window = (req_addr[63:16] == BASE_ADDR[63:16]);
  assign sel_msip  = in_window && (req_addr[15:3] == 13'h0000);
  assign sel_cmp   = in_window && (req_addr[15:3] == 13'h0800);
  assign sel_time  = in_window && (req_addr[15:3] == 13'h17FF);
  assign hit       = sel_msip || sel_cmp || sel_time;
  assign wr        = (state == IDLE) && req_valid && req_write && hit;

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      mask[i*8 +: 8] = {8{req_strobe[i]}};
    end
  end

  always_comb begin
    rdata = '0;
    if (sel_msip)      rdata = {63'd0, msip};
    else if (sel_cmp)  rdata = mtimecmp;
    else if (sel_time) rdata = mtime;
  end

  // A store to mtime takes priority over the tick on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      mtime     <= '0;
      mtimecmp  <= '1;
      msip      <= 1'b0;
    end else begin
      prescaler <= tick ? '0 : prescaler + PW'(1);
      if (wr && sel_time)
        mtime <= (mtime & ~mask) | (req_data & mask);
      else if (tick)
        mtime <= mtime + 64'd1;
      if (wr && sel_cmp)
        mtimecmp <= (mtimecmp & ~mask) | (req_data & mask);
      if (wr && sel_msip && req_strobe[0])
        msip <= req_data[0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_error <= !hit;
            resp_data  <= (req_write || !hit) ? '0 : rdata;
          end
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign trint = (mtime >= mtimecmp);
  assign swint = msip;

endmodule
